// File: rtl/pwm_button_ctrl_pkg.sv
// Shared constants for the button-controlled PWM generator:
// reset settings, button lane indices and the period ceiling helper.
package pwm_button_ctrl_pkg;

  localparam int RST_PERIOD = 64;
  localparam int RST_DUTY   = 32;

  localparam int BTN_INC_DUTY = 0;
  localparam int BTN_DEC_DUTY = 1;
  localparam int BTN_INC_FREQ = 2;
  localparam int BTN_DEC_FREQ = 3;

  // Largest multiple of step that still fits in a cnt_w-bit register.
  function automatic int pmax(input int cnt_w, input int step);
    return (((1 << cnt_w) - 1) / step) * step;
  endfunction

endpackage

// File: rtl/pwm_button_ctrl_debounce.sv
// Two-flop synchroniser plus hold counter turning a raw button
// into exactly one single-clock pulse per accepted press.
module button_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic sync1_q;
  logic sync2_q;
  logic armed_q;
  logic armed_d;
  logic pulse_q;
  logic pulse_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Armed waits for a high run, disarmed waits for a low run.
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (armed_q == sync2_q) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        armed_d = ~armed_q;
        pulse_d = armed_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/pwm_button_ctrl.sv
// Button-stepped PWM: requested duty/period saturate on presses and
// are copied to the active registers only at the counter wrap.
module pwm_button_ctrl
  import pwm_button_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8,
  parameter int STEP      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic increase_duty_bt,
  input  logic decrease_duty_bt,
  input  logic increase_freq_bt,
  input  logic decrease_freq_bt,
  output logic pwm_out
);

  localparam int W = CNT_W + 1;
  localparam logic [CNT_W-1:0] STEP_N = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] PMAX_N = CNT_W'(pmax(CNT_W, STEP));
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [W-1:0] STEP_W  = W'(STEP);
  localparam logic [W-1:0] STEP2_W = W'(2 * STEP);
  localparam logic [W-1:0] PMAX_W  = W'(pmax(CNT_W, STEP));

  logic [3:0] btn;
  logic [3:0] pulse;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_a_q, period_a_d;
  logic [CNT_W-1:0] duty_a_q, duty_a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_t;
  logic             pwm_q, pwm_d;
  logic             wrap;

  assign btn = {decrease_freq_bt, increase_freq_bt,
                decrease_duty_bt, increase_duty_bt};

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn[i]),
      .press_pulse(pulse[i])
    );
  end

  always_comb begin
    period_d = period_q;
    if (pulse[BTN_INC_FREQ] && !pulse[BTN_DEC_FREQ]) begin
      if ({1'b0, period_q} < STEP2_W) period_d = STEP_N;
      else                             period_d = period_q - STEP_N;
    end else if (pulse[BTN_DEC_FREQ] && !pulse[BTN_INC_FREQ]) begin
      if ({1'b0, period_q} + STEP_W > PMAX_W) period_d = PMAX_N;
      else                                    period_d = period_q + STEP_N;
    end

    duty_t = duty_q;
    if (pulse[BTN_INC_DUTY] && !pulse[BTN_DEC_DUTY]) begin
      if ({1'b0, duty_q} + STEP_W > {1'b0, period_d}) duty_t = period_d;
      else                                          duty_t = duty_q + STEP_N;
    end else if (pulse[BTN_DEC_DUTY] && !pulse[BTN_INC_DUTY]) begin
      if (duty_q < STEP_N) duty_t = '0;
      else                 duty_t = duty_q - STEP_N;
    end
    // A shrinking period drags the duty down with it.
    duty_d = (duty_t > period_d) ? period_d : duty_t;
  end

  always_comb begin
    wrap       = (cnt_q == period_a_q - ONE);
    cnt_d      = wrap ? '0 : cnt_q + ONE;
    period_a_d = wrap ? period_q : period_a_q;
    duty_a_d   = wrap ? duty_q : duty_a_q;
    pwm_d      = (cnt_q < duty_a_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q   <= CNT_W'(RST_PERIOD);
      duty_q     <= CNT_W'(RST_DUTY);
      period_a_q <= CNT_W'(RST_PERIOD);
      duty_a_q   <= CNT_W'(RST_DUTY);
      cnt_q      <= '0;
      pwm_q      <= 1'b0;
    end else begin
      period_q   <= period_d;
      duty_q     <= duty_d;
      period_a_q <= period_a_d;
      duty_a_q   <= duty_a_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_button_ctrl.sv
// Directed bench: drives button presses and measures pwm_out high
// time and period against hand-computed duty/period values.
`timescale 1ns/100ps
module tb_pwm_button_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       pwm_out;
  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  pwm_button_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .increase_duty_bt(btn[0]),
    .decrease_duty_bt(btn[1]),
    .increase_freq_bt(btn[2]),
    .decrease_freq_bt(btn[3]),
    .pwm_out         (pwm_out)
  );

  task automatic press(input logic [3:0] m, input int hold);
    @(negedge clk);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = 4'b0;
    repeat (50) @(negedge clk);
  endtask

  // Settle past one wrap, then time one full cycle from a rising edge.
  task automatic measure(output int hi, output int per);
    logic prev;
    int n;
    hi  = -1;
    per = -1;
    repeat (260) @(negedge clk);
    prev = pwm_out;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!prev && pwm_out) break;
      prev = pwm_out;
    end
    if (n == 600) return;
    hi = 1;
    n  = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (!pwm_out) break;
      hi++;
    end
    per = hi + 1;
    while (n < 1200) begin
      @(negedge clk);
      n++;
      if (pwm_out) break;
      per++;
    end
  endtask

  task automatic hold_level(input logic lvl, output int bad);
    bad = 0;
    repeat (260) @(negedge clk);
    repeat (300) begin
      @(negedge clk);
      if (pwm_out !== lvl) bad++;
    end
  endtask

  task automatic test_reset;
    int hi, per;
    rst = 1'b1;
    btn = 4'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_pwm got %b want 0", pwm_out);
    end
    rst = 1'b0;
    measure(hi, per);
    checks++;
    if (hi != 32 || per != 64) begin
      errors++;
      $display("FAIL reset_wave got hi=%0d per=%0d want 32/64", hi, per);
    end
  endtask

  task automatic test_inc_duty;
    int hi, per, bad;
    for (int k = 1; k <= 3; k++) begin
      press(4'b0001, 10);
      measure(hi, per);
      checks++;
      if (hi != 32 + 8 * k || per != 64) begin
        errors++;
        $display("FAIL inc_duty_%0d got hi=%0d per=%0d want %0d/64",
                 k, hi, per, 32 + 8 * k);
      end
    end
    for (int k = 4; k <= 5; k++) begin
      press(4'b0001, 10);
      hold_level(1'b1, bad);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL inc_duty_full_%0d got %0d low samples want 0", k, bad);
      end
    end
  endtask

  task automatic test_dec_duty;
    int hi, per, bad;
    for (int k = 1; k <= 7; k++) begin
      press(4'b0010, 10);
      measure(hi, per);
      checks++;
      if (hi != 64 - 8 * k || per != 64) begin
        errors++;
        $display("FAIL dec_duty_%0d got hi=%0d per=%0d want %0d/64",
                 k, hi, per, 64 - 8 * k);
      end
    end
    for (int k = 8; k <= 9; k++) begin
      press(4'b0010, 10);
      hold_level(1'b0, bad);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL dec_duty_zero_%0d got %0d high samples want 0", k, bad);
      end
    end
  endtask

  task automatic test_glitch;
    int hi, per;
    repeat (6) press(4'b0001, 10);
    measure(hi, per);
    checks++;
    if (hi != 48 || per != 64) begin
      errors++;
      $display("FAIL glitch_setup got hi=%0d per=%0d want 48/64", hi, per);
    end
    for (int b = 0; b < 4; b++) begin
      press(4'(1 << b), 3);
      measure(hi, per);
      checks++;
      if (hi != 48 || per != 64) begin
        errors++;
        $display("FAIL glitch_btn%0d got hi=%0d per=%0d want 48/64",
                 b, hi, per);
      end
    end
  endtask

  task automatic test_freq;
    int hi, per, bad;
    press(4'b0100, 10);
    measure(hi, per);
    checks++;
    if (hi != 48 || per != 56) begin
      errors++;
      $display("FAIL inc_freq_56 got hi=%0d per=%0d want 48/56", hi, per);
    end
    for (int k = 2; k <= 7; k++) begin
      press(4'b0100, 10);
      hold_level(1'b1, bad);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL inc_freq_clamp_%0d got %0d low samples want 0", k, bad);
      end
    end
    press(4'b1000, 10);
    measure(hi, per);
    checks++;
    if (hi != 8 || per != 16) begin
      errors++;
      $display("FAIL freq_floor got hi=%0d per=%0d want 8/16", hi, per);
    end
    repeat (28) press(4'b1000, 10);
    measure(hi, per);
    checks++;
    if (hi != 8 || per != 240) begin
      errors++;
      $display("FAIL dec_freq_240 got hi=%0d per=%0d want 8/240", hi, per);
    end
    for (int k = 0; k < 2; k++) begin
      press(4'b1000, 10);
      measure(hi, per);
      checks++;
      if (hi != 8 || per != 248) begin
        errors++;
        $display("FAIL dec_freq_max_%0d got hi=%0d per=%0d want 8/248",
                 k, hi, per);
      end
    end
  endtask

  task automatic test_both_duty;
    int hi, per;
    press(4'b0011, 10);
    measure(hi, per);
    checks++;
    if (hi != 8 || per != 248) begin
      errors++;
      $display("FAIL both_duty got hi=%0d per=%0d want 8/248", hi, per);
    end
  endtask

  task automatic test_mid_cycle;
    logic prev;
    int n, c1, c2;
    prev = pwm_out;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!prev && pwm_out) break;
      prev = pwm_out;
    end
    btn  = 4'b0100;
    prev = pwm_out;
    c1   = 0;
    while (c1 < 600) begin
      @(negedge clk);
      c1++;
      if (c1 == 10) btn = 4'b0;
      if (!prev && pwm_out) break;
      prev = pwm_out;
    end
    btn  = 4'b0;
    prev = pwm_out;
    c2   = 0;
    while (c2 < 600) begin
      @(negedge clk);
      c2++;
      if (!prev && pwm_out) break;
      prev = pwm_out;
    end
    checks++;
    if (c1 != 248) begin
      errors++;
      $display("FAIL mid_cycle_old got %0d want 248", c1);
    end
    checks++;
    if (c2 != 240) begin
      errors++;
      $display("FAIL mid_cycle_new got %0d want 240", c2);
    end
  endtask

  task automatic test_reset_mid;
    int hi, per;
    @(negedge clk);
    btn = 4'b0001;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    btn = 4'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pwm got %b want 0", pwm_out);
    end
    rst = 1'b0;
    measure(hi, per);
    checks++;
    if (hi != 32 || per != 64) begin
      errors++;
      $display("FAIL reset_mid_wave got hi=%0d per=%0d want 32/64", hi, per);
    end
  endtask

  initial begin
    test_reset;
    test_inc_duty;
    test_dec_duty;
    test_glitch;
    test_freq;
    test_both_duty;
    test_mid_cycle;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
